// File: rtl/multicycle_controller_pkg.sv
// Shared encodings for the multi-cycle RV32I control path: opcodes, datapath
// select codes, ALU control values and the sequencing FSM state codes.
package multicycle_controller_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b0001;
  localparam logic [3:0] ALU_AND   = 4'b0010;
  localparam logic [3:0] ALU_OR    = 4'b0011;
  localparam logic [3:0] ALU_XOR   = 4'b0100;
  localparam logic [3:0] ALU_SLT   = 4'b0101;
  localparam logic [3:0] ALU_SLTU  = 4'b0110;
  localparam logic [3:0] ALU_SLL   = 4'b0111;
  localparam logic [3:0] ALU_SRL   = 4'b1000;
  localparam logic [3:0] ALU_SRA   = 4'b1001;
  localparam logic [3:0] ALU_PASSB = 4'b1010;

  // Coarse ALU intent handed from the FSM to alu_decoder.
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_BR    = 2'b01;
  localparam logic [1:0] ALUOP_FN    = 2'b10;
  localparam logic [1:0] ALUOP_PASSB = 2'b11;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_U = 3'b011;
  localparam logic [2:0] IMM_J = 3'b100;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MEM    = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;
  localparam logic [1:0] RES_PC     = 2'b11;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [3:0] S_FETCH     = 4'd0;
  localparam logic [3:0] S_DECODE    = 4'd1;
  localparam logic [3:0] S_MEMADR    = 4'd2;
  localparam logic [3:0] S_MEMRD     = 4'd3;
  localparam logic [3:0] S_MEMWB     = 4'd4;
  localparam logic [3:0] S_MEMWR     = 4'd5;
  localparam logic [3:0] S_EXEC_R    = 4'd6;
  localparam logic [3:0] S_EXEC_I    = 4'd7;
  localparam logic [3:0] S_ALUWB     = 4'd8;
  localparam logic [3:0] S_BRANCH    = 4'd9;
  localparam logic [3:0] S_JAL       = 4'd10;
  localparam logic [3:0] S_JALR_LINK = 4'd11;
  localparam logic [3:0] S_JALR_JMP  = 4'd12;
  localparam logic [3:0] S_LUI       = 4'd13;
  localparam logic [3:0] S_AUIPC     = 4'd14;
  localparam logic [3:0] S_TRAP      = 4'd15;

  function automatic logic [2:0] imm_sel(input logic [6:0] op);
    case (op)
      OP_STORE:         imm_sel = IMM_S;
      OP_BRANCH:        imm_sel = IMM_B;
      OP_LUI, OP_AUIPC: imm_sel = IMM_U;
      OP_JAL:           imm_sel = IMM_J;
      default:          imm_sel = IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_controller_alu_decoder.sv
// Maps the FSM's coarse ALU intent plus funct fields to the 4-bit ALU control.
module alu_decoder
  import multicycle_controller_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       funct75,
  input  logic       op5,
  input  logic [1:0] alu_op,
  output logic [3:0] alucontrol
);

  always_comb begin
    alucontrol = ALU_ADD;
    case (alu_op)
      ALUOP_BR: begin
        case (funct3[2:1])
          2'b10:   alucontrol = ALU_SLT;
          2'b11:   alucontrol = ALU_SLTU;
          default: alucontrol = ALU_SUB;
        endcase
      end
      ALUOP_FN: begin
        // IR[30] is an immediate bit for ADDI, so SUB only applies to R-type.
        case (funct3)
          3'b000:  alucontrol = (op5 && funct75) ? ALU_SUB : ALU_ADD;
          3'b001:  alucontrol = ALU_SLL;
          3'b010:  alucontrol = ALU_SLT;
          3'b011:  alucontrol = ALU_SLTU;
          3'b100:  alucontrol = ALU_XOR;
          3'b101:  alucontrol = funct75 ? ALU_SRA : ALU_SRL;
          3'b110:  alucontrol = ALU_OR;
          default: alucontrol = ALU_AND;
        endcase
      end
      ALUOP_PASSB: alucontrol = ALU_PASSB;
      default:     alucontrol = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Sequencing FSM for the multi-cycle RV32I core: drives datapath selects and
// strobes, handshakes with memory, counts retired instructions, traps bad opcodes.
module multicycle_controller
  import multicycle_controller_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic             funct75,
  input  logic             mem_ready,
  input  logic             branch_taken,
  output logic             mem_req,
  output logic             mem_we,
  output logic             adr_src,
  output logic             ir_we,
  output logic             pc_we,
  output logic [1:0]       alusrc_a,
  output logic [1:0]       alusrc_b,
  output logic [3:0]       alucontrol,
  output logic [2:0]       immsrc,
  output logic [1:0]       resultsrc,
  output logic             reg_we,
  output logic             retire,
  output logic [CNT_W-1:0] instret,
  output logic             illegal,
  output logic [3:0]       state_o
);

  logic [3:0]       state_q, state_d;
  logic [CNT_W-1:0] instret_q, instret_d;
  logic             illegal_q, illegal_d;
  logic [1:0]       alu_op;

  alu_decoder u_alu_decoder (
    .funct3     (funct3),
    .funct75    (funct75),
    .op5        (opcode[5]),
    .alu_op     (alu_op),
    .alucontrol (alucontrol)
  );

  always_comb begin
    state_d   = state_q;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    adr_src   = 1'b0;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    alusrc_a  = SRCA_PC;
    alusrc_b  = SRCB_RS2;
    immsrc    = IMM_I;
    resultsrc = RES_ALUOUT;
    reg_we    = 1'b0;
    retire    = 1'b0;
    alu_op    = ALUOP_ADD;
    case (state_q)
      S_FETCH: begin
        mem_req   = 1'b1;
        alusrc_b  = SRCB_FOUR;
        resultsrc = RES_ALU;
        if (mem_ready) begin
          ir_we   = 1'b1;
          pc_we   = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        alusrc_a = SRCA_OLDPC;
        alusrc_b = SRCB_IMM;
        immsrc   = imm_sel(opcode);
        case (opcode)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_R:              state_d = S_EXEC_R;
          OP_I:              state_d = S_EXEC_I;
          OP_BRANCH:         state_d = S_BRANCH;
          OP_JAL:            state_d = S_JAL;
          OP_JALR:           state_d = S_JALR_LINK;
          OP_LUI:            state_d = S_LUI;
          OP_AUIPC:          state_d = S_AUIPC;
          default:           state_d = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        alusrc_a = SRCA_RS1;
        alusrc_b = SRCB_IMM;
        immsrc   = imm_sel(opcode);
        state_d  = (opcode == OP_STORE) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        resultsrc = RES_MEM;
        reg_we    = 1'b1;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
      S_MEMWR: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        adr_src = 1'b1;
        if (mem_ready) begin
          retire  = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_EXEC_R, S_EXEC_I: begin
        alusrc_a = SRCA_RS1;
        alusrc_b = (state_q == S_EXEC_R) ? SRCB_RS2 : SRCB_IMM;
        immsrc   = IMM_I;
        alu_op   = ALUOP_FN;
        state_d  = S_ALUWB;
      end
      S_ALUWB: begin
        resultsrc = RES_ALUOUT;
        reg_we    = 1'b1;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
      S_BRANCH: begin
        alusrc_a  = SRCA_RS1;
        alusrc_b  = SRCB_RS2;
        alu_op    = ALUOP_BR;
        resultsrc = RES_ALUOUT;
        pc_we     = branch_taken;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
      S_JAL: begin
        resultsrc = RES_PC;
        reg_we    = 1'b1;
        pc_we     = 1'b1;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
      // rd must capture PC before it is overwritten, so link and jump take separate cycles.
      S_JALR_LINK, S_JALR_JMP: begin
        alusrc_a = SRCA_RS1;
        alusrc_b = SRCB_IMM;
        immsrc   = IMM_I;
        if (state_q == S_JALR_LINK) begin
          resultsrc = RES_PC;
          reg_we    = 1'b1;
          state_d   = S_JALR_JMP;
        end else begin
          resultsrc = RES_ALU;
          pc_we     = 1'b1;
          retire    = 1'b1;
          state_d   = S_FETCH;
        end
      end
      S_LUI: begin
        alusrc_b  = SRCB_IMM;
        immsrc    = IMM_U;
        alu_op    = ALUOP_PASSB;
        resultsrc = RES_ALU;
        reg_we    = 1'b1;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
      S_AUIPC: begin
        alusrc_a = SRCA_OLDPC;
        alusrc_b = SRCB_IMM;
        immsrc   = IMM_U;
        state_d  = S_ALUWB;
      end
      default: state_d = S_TRAP;
    endcase
    // Reset masks every strobe combinationally so an aborted instruction writes nothing.
    if (rst) begin
      state_d   = S_FETCH;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      adr_src   = 1'b0;
      ir_we     = 1'b0;
      pc_we     = 1'b0;
      alusrc_a  = SRCA_PC;
      alusrc_b  = SRCB_RS2;
      immsrc    = IMM_I;
      resultsrc = RES_ALUOUT;
      reg_we    = 1'b0;
      retire    = 1'b0;
      alu_op    = ALUOP_ADD;
    end
  end

  always_comb begin
    instret_d = retire ? instret_q + CNT_W'(1) : instret_q;
    illegal_d = illegal_q | (state_d == S_TRAP);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      instret_q <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      instret_q <= instret_d;
      illegal_q <= illegal_d;
    end
  end

  assign instret = instret_q;
  assign illegal = illegal_q;
  assign state_o = state_q;

endmodule
